// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage of a simple RISC-V style pipeline.
// Combinational loads with byte/half/word extraction and sign/zero extension.
// Stores are byte-lane masked and commit on the rising edge.
// A sticky error flag records illegal or misaligned accesses, and a
// saturating counter tracks committed stores.
// Loads assume the 32-bit byte-lane layout. Any bits above 31 (WIDTH > 32)
// are carried only by word accesses.
module mem_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] mem_out,
  output logic             misalign_err,
  output logic [15:0]      store_count
);

  localparam int AW = $clog2(DEPTH);

  // The memory must clear in one reset cycle, so it is held in flops
  // rather than block RAM.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_err;
  logic [15:0]      r_count;

  logic [AW-1:0]    w_idx;
  logic [1:0]       w_lane;
  logic             w_is_byte;
  logic             w_is_half;
  logic             w_is_word;
  logic             w_load_legal;
  logic             w_illegal;
  logic             w_misalign;
  logic             w_store_ok;
  logic             w_err_evt;
  logic [WIDTH-1:0] w_rword;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_wword;
  logic             w_unused;

  // The upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
  assign w_idx    = alu_out[AW+1:2];
  assign w_lane   = alu_out[1:0];
  assign w_unused = ^alu_out[WIDTH-1:AW+2];

  assign w_is_byte    = (funct3[1:0] == 2'b00);
  assign w_is_half    = (funct3[1:0] == 2'b01);
  assign w_is_word    = (funct3[1:0] == 2'b10);
  assign w_load_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b101);
  // The unsigned encodings (100/101) have no meaning for a store.
  assign w_illegal    = !w_load_legal || (memwrite && funct3[2]);
  assign w_misalign   = (w_is_half && alu_out[0]) || (w_is_word && (w_lane != 2'b00));
  assign w_store_ok   = memwrite && !w_illegal && !w_misalign;
  assign w_err_evt    = (memread || memwrite) && (w_illegal || w_misalign);

  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
  assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

  // Load formatting: lane select plus sign or zero extension; zero when not a valid load.
  always_comb begin
    w_load = '0;
    if (memread && !w_illegal && !w_misalign) begin
      if (w_is_byte)
        w_load = {{(WIDTH-8){~funct3[2] & w_byte[7]}}, w_byte};
      else if (w_is_half)
        w_load = {{(WIDTH-16){~funct3[2] & w_half[15]}}, w_half};
      else
        w_load = w_rword;
    end
  end

  assign mem_out = w_load;

  // The store word is built by merging the written lanes into the old word.
  // Unwritten lanes keep their previous contents.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       w_we;
      logic [7:0] w_src;
      assign w_we  = w_is_word ||
                     (w_is_byte && (w_lane == 2'(gi))) ||
                     (w_is_half && (w_lane[1] == 1'(gi / 2)));
      assign w_src = w_is_word ? rs2_data[8*gi +: 8] :
                     w_is_half ? rs2_data[8*(gi % 2) +: 8] :
                                 rs2_data[7:0];
      assign w_wword[8*gi +: 8] = w_we ? w_src : w_rword[8*gi +: 8];
    end
    if (WIDTH > 32) begin : g_upper
      assign w_wword[WIDTH-1:32] = w_is_word ? rs2_data[WIDTH-1:32] : w_rword[WIDTH-1:32];
    end
  endgenerate

  // Memory array: reset clears every word; otherwise a committed store is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_store_ok) begin
      r_mem[w_idx] <= w_wword;
    end
  end

  // Status: sticky error flag and the saturating store counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err   <= 1'b0;
      r_count <= 16'h0000;
    end else begin
      if (w_err_evt) r_err <= 1'b1;
      if (w_store_ok && (r_count != 16'hFFFF)) r_count <= r_count + 16'h0001;
    end
  end

  assign misalign_err = r_err;
  assign store_count  = r_count;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// The stimulus process drives one access per cycle and queues the expected
// outputs from a byte-addressed reference memory. The monitor checks the
// queued values against the DUT on the falling edge.
module tb_mem_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int NBYTES = 4 * DEPTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] rs2_data;
  logic             memread;
  logic             memwrite;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] mem_out;
  logic             misalign_err;
  logic [15:0]      store_count;

  mem_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_out      (alu_out),
    .rs2_data     (rs2_data),
    .memread      (memread),
    .memwrite     (memwrite),
    .funct3       (funct3),
    .mem_out      (mem_out),
    .misalign_err (misalign_err),
    .store_count  (store_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] exp_out;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   n_txn = 0;

  // Reference model: memory as a flat array of bytes.
  logic [7:0] m_mem [NBYTES];
  logic       m_err;
  int         m_cnt;

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_bad(input logic [2:0] f3, input logic wr, input logic [31:0] a);
    int sz;
    if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if (wr && f3 >= 3'd4) return 1'b1;
    sz = acc_size(f3);
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic rd, input logic wr,
                                             input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int          sz;
    int          base;
    v = 32'h0;
    if (!rd || is_bad(f3, wr, a)) return 32'h0;
    sz   = acc_size(f3);
    base = int'(a % NBYTES);
    for (int k = 0; k < sz; k++) v = v | (32'(m_mem[base + k]) << (8 * k));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic txn(input string name, input logic rn, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   sz;
    int   base;
    @(posedge clk);
    #1;
    rst_n    = rn;
    memread  = rd;
    memwrite = wr;
    funct3   = f3;
    alu_out  = a;
    rs2_data = d;
    e.name    = name;
    e.addr    = a;
    e.exp_out = model_load(rd, wr, f3, a);
    e.exp_err = m_err;
    e.exp_cnt = 16'(m_cnt);
    sb.push_back(e);
    // Apply what the coming edge does to the model state.
    if (!rn) begin
      for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      if ((rd || wr) && is_bad(f3, wr, a)) m_err = 1'b1;
      if (wr && !is_bad(f3, wr, a)) begin
        sz   = acc_size(f3);
        base = int'(a % NBYTES);
        for (int k = 0; k < sz; k++) m_mem[base + k] = d[8*k +: 8];
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Monitor: one scoreboard entry per cycle; the outputs are sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_txn++;
      $display("txn %0d %s addr=%h mem_out=%h err=%b cnt=%0d",
               n_txn, e.name, e.addr, mem_out, misalign_err, store_count);
      n_vec++;
      if (mem_out !== e.exp_out) begin
        n_mis++;
        $display("FAIL %s mem_out got %h want %h", e.name, mem_out, e.exp_out);
      end
      n_vec++;
      if (misalign_err !== e.exp_err) begin
        n_mis++;
        $display("FAIL %s misalign_err got %b want %b", e.name, misalign_err, e.exp_err);
      end
      n_vec++;
      if (store_count !== e.exp_cnt) begin
        n_mis++;
        $display("FAIL %s store_count got %0d want %0d", e.name, store_count, e.exp_cnt);
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          sz;
    rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0;
    alu_out = '0; rs2_data = '0;
    for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
    m_err = 1'b0;
    m_cnt = 0;
    repeat (2) @(posedge clk);

    // Directed sequence: load/store basics, extension, partial stores, errors, wrap, reset.
    txn("LW_rst",  1, 1, 0, 3'b010, 32'h10,  32'h0);
    txn("SW",      1, 0, 1, 3'b010, 32'h10,  32'hDEAD_BEEF);
    txn("LW",      1, 1, 0, 3'b010, 32'h10,  32'h0);
    txn("LB",      1, 1, 0, 3'b000, 32'h13,  32'h0);
    txn("LBU",     1, 1, 0, 3'b100, 32'h13,  32'h0);
    txn("LH",      1, 1, 0, 3'b001, 32'h10,  32'h0);
    txn("LHU",     1, 1, 0, 3'b101, 32'h12,  32'h0);
    txn("SB",      1, 0, 1, 3'b000, 32'h11,  32'h1234_5677);
    txn("LW_sb",   1, 1, 0, 3'b010, 32'h10,  32'h0);
    txn("SH",      1, 0, 1, 3'b001, 32'h12,  32'h0000_ABCD);
    txn("LW_sh",   1, 1, 0, 3'b010, 32'h10,  32'h0);
    txn("RWsame",  1, 1, 1, 3'b010, 32'h10,  32'h0BAD_F00D);
    txn("LW_rw",   1, 1, 0, 3'b010, 32'h10,  32'h0);
    txn("SW_20",   1, 0, 1, 3'b010, 32'h20,  32'h1122_3344);
    txn("SW_mis",  1, 0, 1, 3'b010, 32'h22,  32'hFFFF_FFFF);
    txn("LW_20",   1, 1, 0, 3'b010, 32'h20,  32'h0);
    txn("LH_mis",  1, 1, 0, 3'b001, 32'h21,  32'h0);
    txn("SBU_ill", 1, 0, 1, 3'b100, 32'h20,  32'h0);
    txn("LD_ill",  1, 1, 0, 3'b011, 32'h20,  32'h0);
    txn("SW_wrap", 1, 0, 1, 3'b010, 32'h400, 32'h5A5A_5A5A);
    txn("LW_0",    1, 1, 0, 3'b010, 32'h0,   32'h0);
    txn("SW_rst",  0, 0, 1, 3'b010, 32'h4,   32'h7777_7777);
    txn("LW_0r",   1, 1, 0, 3'b010, 32'h0,   32'h0);
    txn("LW_4r",   1, 1, 0, 3'b010, 32'h4,   32'h0);

    // Random traffic over a small window so that accesses collide.
    // Random upper bits exercise the address wrap.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 99) < 80) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      sz = acc_size(f3);
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) a = a & ~(32'(sz) - 32'd1);
      a = ($urandom & 32'hFFFF_FFC0) | a;
      txn("RND", ($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0), f3, a, $urandom);
    end

    // Let the monitor drain the scoreboard, within a fixed cycle budget.
    repeat (4) @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter WIDTH, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 256, number of WIDTH-bit data memory words (power of two).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 alu_out  input  WIDTH  effective byte address of the load/store.
REQ-006 rs2_data  input  WIDTH  store data.
REQ-007 memread  input  1  load request for the current instruction.
REQ-008 memwrite  input  1  store request for the current instruction.
REQ-009 funct3  input  3  access size and signedness.
REQ-010 mem_out  output  WIDTH  load result, consumed by the write-back stage.
REQ-011 misalign_err  output  1  sticky flag for a rejected access.
REQ-012 store_count  output  16  count of committed stores.

Function
REQ-013 Word index SHALL be alu_out[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-014 Byte lane SHALL be alu_out[1:0], little-endian: lane 0 = bits 7:0.
REQ-015 funct3 encoding: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; all other values are illegal.
REQ-016 Stores SHALL use 000/001/010 only; 100/101 with memwrite are illegal.
REQ-017 An access is misaligned when it is a half with alu_out[0]=1, or a word with alu_out[1:0]!=00.
REQ-018 Reads SHALL be combinational: mem_out reflects the current inputs and memory contents in the same cycle, with zero latency.
REQ-019 If memread=0, or the access is illegal or misaligned, mem_out SHALL be 0.
REQ-020 A byte load SHALL select the addressed lane; a half load SHALL select bits 15:0 or 31:16 by alu_out[1]. The result is sign-extended for 000/001 and zero-extended for 100/101.
REQ-021 A store SHALL commit on the rising edge when rst_n=1, memwrite=1, funct3 is legal and the access is aligned.
REQ-022 A committed store SHALL write only the addressed byte or half lanes; the other lanes of the word are preserved. Stored data is the low 8, 16 or 32 bits of rs2_data.
REQ-023 An illegal or misaligned store SHALL leave memory unchanged.
REQ-024 Read during write to the same word: mem_out shows the old contents before the edge and the new contents after it; there is no bypass.
REQ-025 memread=1 and memwrite=1 together SHALL perform both: the combinational read of the old data and the store at the edge.
REQ-026 misalign_err SHALL set at the edge following any cycle with (memread or memwrite)=1 and an illegal or misaligned access. Once set, it holds until reset.
REQ-027 store_count SHALL increment by 1 on each committed store and saturate at 16'hFFFF, with no wrap.
REQ-028 Reset SHALL take priority over a store in the same cycle.

Reset
REQ-029 While rst_n=0 at a rising edge, all DEPTH memory words SHALL clear to 0, misalign_err SHALL clear to 0, and store_count SHALL clear to 0.
REQ-030 After reset, mem_out SHALL be 0 for any load until a store commits.
REQ-031 Reset asserted mid-sequence SHALL discard any pending state; no store issued in the reset cycle takes effect.

Verification
REQ-032 Word store/load: SW 32'hDEADBEEF at address 0x10, then LW 0x10 -> mem_out=32'hDEADBEEF, store_count=1.
REQ-033 Byte and half extension: after REQ-032, LB 0x13 -> 32'hFFFFFFDE; LBU 0x13 -> 32'h000000DE; LH 0x10 -> 32'hFFFFBEEF; LHU 0x12 -> 32'h0000DEAD.
REQ-034 Partial store: SB rs2_data=32'h12345677 at 0x11 over 32'hDEADBEEF -> LW 0x10 = 32'hDEAD77EF. Then SH 32'h0000ABCD at 0x12 -> LW 0x10 = 32'hABCD77EF.
REQ-035 Misalignment: SW at 0x22 -> memory at 0x20 unchanged, misalign_err=1 after the edge, store_count unchanged. LH 0x21 -> mem_out=0. misalign_err stays 1 until rst_n=0.
REQ-036 Wrap and reset: with DEPTH=256, SW 32'h5A5A5A5A at 0x400 -> LW 0x0 = 32'h5A5A5A5A. Assert rst_n=0 together with SW 0x4 -> after the edge, LW 0x0 = 0, LW 0x4 = 0, store_count = 0.
